// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: runs the req/ack data-memory access,
// stalls the front of the pipeline while it is outstanding and owns MEM/WB.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  WB_i,
  input  logic [1:0]  Mem_i,
  input  logic [31:0] alu_ans_i,
  input  logic [31:0] rtdata_i,
  input  logic [4:0]  WBreg_i,
  input  logic [31:0] pc_add4_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_o,
  output logic [2:0]  WB_o,
  output logic [31:0] rdata_o,
  output logic [31:0] alu_ans_o,
  output logic [4:0]  WBreg_o,
  output logic [31:0] pc_add4_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic        we_reg;
  logic [31:0] addr_reg, wdata_reg;

  logic        access, illegal, misaligned, start, timeout_hit, stall_raw;
  logic [2:0]  wb_next;
  logic [31:0] rdata_next, alu_next, pc_next;
  logic [4:0]  wbreg_next;
  logic        err_next;
  logic [1:0]  code_next;

  assign access      = (Mem_i != 2'b00);
  assign illegal     = (Mem_i == 2'b11);
  assign misaligned  = access && (alu_ans_i[1:0] != 2'b00);
  assign start       = (state_reg == IDLE) && access && !illegal && !misaligned;
  assign timeout_hit = (state_reg == BUSY) && !mem_ack_i &&
                       (cnt_reg == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (mem_ack_i || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: stall and the value MEM/WB takes at the next edge
  always_comb begin
    stall_raw  = 1'b0;
    wb_next    = WB_i;
    rdata_next = '0;
    alu_next   = alu_ans_i;
    wbreg_next = WBreg_i;
    pc_next    = pc_add4_i;
    err_next   = 1'b0;
    code_next  = err_code_o;
    case (state_reg)
      IDLE: begin
        if (illegal) begin
          wb_next   = '0;
          err_next  = 1'b1;
          code_next = ERR_ILLEGAL;
        end else if (misaligned) begin
          wb_next   = '0;
          err_next  = 1'b1;
          code_next = ERR_MISALIGN;
        end else if (access) begin
          stall_raw  = 1'b1;
          wb_next    = '0;
          alu_next   = '0;
          wbreg_next = '0;
          pc_next    = '0;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          rdata_next = we_reg ? 32'd0 : mem_rdata_i;
        end else if (timeout_hit) begin
          wb_next   = '0;
          err_next  = 1'b1;
          code_next = ERR_TIMEOUT;
        end else begin
          stall_raw  = 1'b1;
          wb_next    = '0;
          alu_next   = '0;
          wbreg_next = '0;
          pc_next    = '0;
        end
      end
      default: ;
    endcase
  end

  // Reset forces stall low even while an access is still presented on EX/MEM
  assign stall_o     = rst_i && stall_raw;
  assign mem_req_o   = (state_reg == BUSY);
  assign mem_we_o    = we_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (start) begin
      cnt_reg   <= '0;
      we_reg    <= Mem_i[0];
      addr_reg  <= {alu_ans_i[31:2], 2'b00};
      wdata_reg <= rtdata_i;
    end else if (state_reg == BUSY && !mem_ack_i) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // MEM/WB pipeline register and error flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      WB_o       <= '0;
      rdata_o    <= '0;
      alu_ans_o  <= '0;
      WBreg_o    <= '0;
      pc_add4_o  <= '0;
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else begin
      WB_o       <= wb_next;
      rdata_o    <= rdata_next;
      alu_ans_o  <= alu_next;
      WBreg_o    <= wbreg_next;
      pc_add4_o  <= pc_next;
      err_o      <= err_next;
      err_code_o <= code_next;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage: the driver pushes the
// expected MEM/WB result of each instruction, a monitor pops it on retirement.
module tb_mem_access_stage;
  localparam int TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [2:0]  WB_i = '0;
  logic [1:0]  Mem_i = '0;
  logic [31:0] alu_ans_i = '0, rtdata_i = '0, pc_add4_i = '0;
  logic [4:0]  WBreg_i = '0;
  logic        mem_req_o, mem_we_o, stall_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rdata_o, alu_ans_o, pc_add4_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [2:0]  WB_o;
  logic [4:0]  WBreg_o;
  logic [1:0]  err_code_o;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .Mem_i(Mem_i),
    .alu_ans_i(alu_ans_i), .rtdata_i(rtdata_i), .WBreg_i(WBreg_i),
    .pc_add4_i(pc_add4_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .stall_o(stall_o),
    .WB_o(WB_o), .rdata_o(rdata_o), .alu_ans_o(alu_ans_o), .WBreg_o(WBreg_o),
    .pc_add4_o(pc_add4_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  wb;
    logic [31:0] rdata, alu, pc;
    logic [4:0]  wbreg;
    logic        err;
    logic [1:0]  code;
    int          stalls, reqs;
  } exp_t;

  exp_t exp_q[$];
  int total = 0, bad = 0;

  // Shared between the driver and the memory responder
  int          cur_d = 0;
  logic [31:0] cur_rdata = '0, cur_addr = '0, cur_wdata = '0;
  logic        cur_we = 1'b0;
  bit          resp_en = 1'b1, force_ack = 1'b0, active = 1'b0;
  logic [31:0] force_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: what an instruction leaves in MEM/WB and how long it holds the pipe
  function automatic exp_t model(input logic [1:0] mem, input logic [2:0] wb,
                                 input logic [31:0] alu, input logic [4:0] wbreg,
                                 input logic [31:0] pc, input int d, input logic [31:0] rd);
    exp_t e;
    e.wb = wb; e.rdata = '0; e.alu = alu; e.wbreg = wbreg; e.pc = pc;
    e.err = 1'b0; e.code = 2'b00; e.stalls = 0; e.reqs = 0;
    if (mem == 2'b11) begin
      e.wb = '0; e.err = 1'b1; e.code = 2'b11;
    end else if (mem != 2'b00 && alu[1:0] != 2'b00) begin
      e.wb = '0; e.err = 1'b1; e.code = 2'b01;
    end else if (mem != 2'b00) begin
      if (d < TIMEOUT) begin
        e.stalls = d + 1;
        e.reqs   = d + 1;
        if (mem == 2'b10) e.rdata = rd;
      end else begin
        e.stalls = TIMEOUT;
        e.reqs   = TIMEOUT;
        e.wb = '0; e.err = 1'b1; e.code = 2'b10;
      end
    end
    return e;
  endfunction

  task automatic issue(input logic [1:0] mem, input logic [2:0] wb, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] wbreg, input logic [31:0] pc,
                       input int d, input logic [31:0] rd);
    int n;
    @(negedge clk_i);
    WB_i = wb; Mem_i = mem; alu_ans_i = alu; rtdata_i = rt; WBreg_i = wbreg; pc_add4_i = pc;
    cur_d = d; cur_rdata = rd; cur_we = mem[0];
    cur_addr = {alu[31:2], 2'b00}; cur_wdata = rt;
    exp_q.push_back(model(mem, wb, alu, wbreg, pc, d, rd));
    $display("issue mem=%b addr=%h wb=%b ack_delay=%0d", mem, alu, wb, d);
    active = 1'b1;
    n = 0;
    forever begin
      #2;
      if (!stall_o) break;
      if (n >= TIMEOUT + 8) begin
        total++; bad++;
        $display("FAIL stall_bound actual=stuck required=release at %0t", $time);
        break;
      end
      n++;
      @(negedge clk_i);
    end
  endtask

  // Memory responder: acks on BUSY cycle cur_d, noise ack/data while idle
  initial begin
    int rc;
    rc = 0;
    forever begin
      @(negedge clk_i);
      if (!resp_en) begin
        mem_ack_i = force_ack; mem_rdata_i = force_rdata; rc = 0;
      end else if (mem_req_o) begin
        chk("req_we", {31'd0, mem_we_o}, {31'd0, cur_we});
        chk("req_addr", mem_addr_o, cur_addr);
        chk("req_wdata", mem_wdata_o, cur_wdata);
        mem_ack_i   = (rc == cur_d);
        mem_rdata_i = (rc == cur_d) ? cur_rdata : $urandom;
        rc++;
      end else begin
        rc = 0;
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
      end
    end
  end

  // Monitor: bubble while stalled, scoreboard pop one cycle after retirement
  initial begin
    int stall_cnt, req_cnt;
    bit pend, prev_stall;
    exp_t e;
    stall_cnt = 0; req_cnt = 0; pend = 1'b0; prev_stall = 1'b0;
    forever begin
      @(negedge clk_i);
      #2;
      if (pend) begin
        pend = 1'b0;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard actual=empty required=entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("wb", {29'd0, WB_o}, {29'd0, e.wb});
          chk("rdata", rdata_o, e.rdata);
          chk("alu_ans", alu_ans_o, e.alu);
          chk("wbreg", {27'd0, WBreg_o}, {27'd0, e.wbreg});
          chk("pc_add4", pc_add4_o, e.pc);
          chk("err", {31'd0, err_o}, {31'd0, e.err});
          if (e.err) chk("err_code", {30'd0, err_code_o}, {30'd0, e.code});
          chk("stall_cycles", stall_cnt, e.stalls);
          chk("req_cycles", req_cnt, e.reqs);
        end
        stall_cnt = 0; req_cnt = 0;
      end else if (prev_stall) begin
        chk("bubble", {31'd0, (|{WB_o, rdata_o, alu_ans_o, WBreg_o, pc_add4_o, err_o})}, 32'd0);
      end
      if (active) begin
        if (mem_req_o) req_cnt++;
        if (stall_o) stall_cnt++;
        else pend = 1'b1;
      end
      prev_stall = active && stall_o;
    end
  end

  initial begin
    int r, d;
    logic [1:0]  m;
    logic [31:0] a;
    #12;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_wb", {29'd0, WB_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    @(negedge clk_i);
    #2 rst_i = 1'b1;

    issue(2'b00, 3'b100, 32'h0000_1234, 32'h0,        5'd1, 32'h4,  0, 32'h0);
    issue(2'b10, 3'b101, 32'h0000_0040, 32'h11,       5'd8, 32'h8,  3, 32'hDEAD_BEEF);
    issue(2'b01, 3'b000, 32'h0000_0080, 32'hCAFE_F00D, 5'd0, 32'hC,  0, 32'h1357_9BDF);
    issue(2'b10, 3'b100, 32'h0000_0042, 32'h0,        5'd3, 32'h10, 0, 32'h0);
    issue(2'b11, 3'b100, 32'h0000_0044, 32'h0,        5'd4, 32'h14, 0, 32'h0);
    issue(2'b10, 3'b100, 32'h0000_0100, 32'h0,        5'd5, 32'h18, TIMEOUT + 4, 32'h0);
    issue(2'b10, 3'b110, 32'h0000_0104, 32'h0,        5'd6, 32'h1C, TIMEOUT - 1, 32'h2468_ACE0);
    issue(2'b01, 3'b000, 32'h0000_0108, 32'h5555_AAAA, 5'd7, 32'h20, TIMEOUT, 32'h0);

    for (int i = 0; i < 60; i++) begin
      m = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      if (r < 7)       d = $urandom_range(0, 4);
      else if (r == 7) d = TIMEOUT - 1;
      else if (r == 8) d = TIMEOUT;
      else             d = TIMEOUT + 3;
      issue(m, 3'($urandom), a, $urandom, 5'($urandom), $urandom, d, $urandom);
    end

    @(negedge clk_i);
    Mem_i = 2'b00;
    active = 1'b0;
    @(negedge clk_i);
    #3 chk("queue_empty", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of an access
    @(negedge clk_i);
    resp_en = 1'b0; force_ack = 1'b0; force_rdata = 32'hA5A5_A5A5;
    Mem_i = 2'b10; alu_ans_i = 32'h0000_0200; WB_i = 3'b100;
    @(negedge clk_i);
    #2 chk("busy_req", {31'd0, mem_req_o}, 32'd1);
    chk("busy_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("async_req", {31'd0, mem_req_o}, 32'd0);
    chk("async_stall", {31'd0, stall_o}, 32'd0);
    chk("async_addr", mem_addr_o, 32'd0);
    chk("async_wb", {29'd0, WB_o}, 32'd0);
    chk("async_err", {31'd0, err_o}, 32'd0);
    $display("reset mid-access req=%b stall=%b", mem_req_o, stall_o);
    Mem_i = 2'b00; alu_ans_i = 32'h77;
    #1 rst_i = 1'b1;
    force_ack = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    chk("late_ack_req", {31'd0, mem_req_o}, 32'd0);
    chk("late_ack_rdata", rdata_o, 32'd0);
    chk("late_ack_wb", {29'd0, WB_o}, 32'h4);
    chk("late_ack_stall", {31'd0, stall_o}, 32'd0);
    chk("late_ack_err", {31'd0, err_o}, 32'd0);
    $display("late ack after reset rdata=%h wb=%b", rdata_o, WB_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
